// File: rtl/nibble_add_sequencer.sv
// Purpose: 8-bit add done as two nibble passes through an external 4-bit ripple-carry adder.
// Latency: operands accepted at the end of cycle c give out_valid=1 in cycle c+3; one result per 4 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until the result is consumed.
module nibble_add_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    input  logic             op_cin,
    output logic [3:0]       rca_A,
    output logic [3:0]       rca_B,
    output logic             rca_Cin,
    input  logic [3:0]       rca_S,
    input  logic             rca_Cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sum,
    output logic             cout,
    output logic             overflow,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             cin_q, cin_d;
    logic             c_mid_q, c_mid_d;
    logic [7:0]       sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register and datapath registers; reset clears everything so the adder drive drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            cin_q   <= 1'b0;
            c_mid_q <= 1'b0;
            sum_q   <= 8'h00;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            c_mid_q <= c_mid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, adder drive and capture logic; every state holds all registers unless it captures.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        c_mid_d   = c_mid_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rca_A     = 4'h0;
        rca_B     = 4'h0;
        rca_Cin   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    cin_d   = op_cin;
                    state_d = LOW;
                end
            end
            LOW: begin
                rca_A      = a_q[3:0];
                rca_B      = b_q[3:0];
                rca_Cin    = cin_q;
                sum_d[3:0] = rca_S;
                c_mid_d    = rca_Cout;
                state_d    = HIGH;
            end
            HIGH: begin
                rca_A      = a_q[7:4];
                rca_B      = b_q[7:4];
                rca_Cin    = c_mid_q;
                sum_d[7:4] = rca_S;
                cout_d     = rca_Cout;
                // Signed overflow: like-signed operands whose result sign (bit 7 = rca_S[3]) differs.
                ovf_d      = (a_q[7] == b_q[7]) && (rca_S[3] != a_q[7]);
                state_d    = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign op_count = cnt_q;

endmodule
